// File: rtl/fb_scanout.sv
// fb_scanout: 800x600@60 SVGA scanout of an 8-bit indexed framebuffer into a registered RGB stream.
// Define FB_SCANOUT_PALETTE_EN for a writable 256x24 palette; otherwise a fixed RGB332 expansion is used.
module fb_scanout #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter int   ADDR_W   = 20,
  parameter int   RD_LAT   = 1,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [7:0]        fb_rd_data,
  input  logic              pal_we,
  input  logic [7:0]        pal_idx,
  input  logic [23:0]       pal_rgb,
  output logic [23:0]       rgb,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] cur_addr;
  logic              sof;
  logic              active;
  logic              hs_on;
  logic              vs_on;
  logic              hs_s0;
  logic              vs_s0;

  assign sof    = (h_cnt == '0) && (v_cnt == '0);
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_on  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_on  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  // On the first pixel of a frame the base comes straight from the port, so it is also the first read address.
  assign cur_addr = sof ? fb_base : addr_cnt;

  // NOTE: clocked state uses non-blocking assignments so every stage samples the previous cycle's values.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      addr_cnt    <= '0;
      fb_rd_en    <= 1'b0;
      fb_rd_addr  <= '0;
      frame_start <= 1'b0;
      hs_s0       <= 1'b0;
      vs_s0       <= 1'b0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      frame_start <= sof;
      fb_rd_en    <= active;
      hs_s0       <= hs_on;
      vs_s0       <= vs_on;
      if (active) begin
        fb_rd_addr <= cur_addr;
        addr_cnt   <= cur_addr + 1'b1;
      end else begin
        addr_cnt   <= cur_addr;
      end
    end
  end

  // Timing flags ride alongside the read until the framebuffer data returns.
  logic [RD_LAT-1:0] act_pipe;
  logic [RD_LAT-1:0] hs_pipe;
  logic [RD_LAT-1:0] vs_pipe;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      act_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
    end else begin
      act_pipe[0] <= fb_rd_en;
      hs_pipe[0]  <= hs_s0;
      vs_pipe[0]  <= vs_s0;
      for (int i = 1; i < RD_LAT; i++) begin
        act_pipe[i] <= act_pipe[i-1];
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
      end
    end
  end

  function automatic logic [23:0] rgb332(input logic [7:0] i);
    return {i[7:5], i[7:5], i[7:6], i[4:2], i[4:2], i[4:3], {4{i[1:0]}}};
  endfunction

  logic [23:0] colour;

`ifdef FB_SCANOUT_PALETTE_EN
  typedef logic [23:0] pal_t [256];

  function automatic pal_t pal_init();
    pal_t p;
    for (int i = 0; i < 256; i++) p[i] = rgb332(8'(i));
    return p;
  endfunction

  // NOTE: the palette RAM is deliberately left out of reset so it maps onto RAM and keeps its contents across rst.
  pal_t pal_mem = pal_init();

  always_ff @(posedge clk) begin
    if (pal_we) pal_mem[pal_idx] <= pal_rgb;
  end

  assign colour = pal_mem[fb_rd_data];
`else
  logic unused_pal;
  assign unused_pal = ^{pal_we, pal_idx, pal_rgb};
  assign colour     = rgb332(fb_rd_data);
`endif

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      rgb   <= '0;
      de    <= 1'b0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
    end else begin
      de    <= act_pipe[RD_LAT-1];
      rgb   <= act_pipe[RD_LAT-1] ? colour : '0;
      hsync <= hs_pipe[RD_LAT-1] ? HS_POL : ~HS_POL;
      vsync <= vs_pipe[RD_LAT-1] ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on a reduced raster so several whole frames fit in a short run.
// A position-based reference model queues the expected stream every cycle; a monitor compares at negedge.
module tb_fb_scanout;

  localparam int HA = 24, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME  = HT * VT;
  localparam int AW     = 20;
  localparam int RD_LAT = 1;
  localparam int D      = RD_LAT + 1;
  localparam logic HS_POL = 1'b1;
  localparam logic VS_POL = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [AW-1:0] fb_base;
  logic          fb_rd_en;
  logic [AW-1:0] fb_rd_addr;
  logic [7:0]    fb_rd_data;
  logic          pal_we;
  logic [7:0]    pal_idx;
  logic [23:0]   pal_rgb;
  logic [23:0]   rgb;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic          frame_start;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .ADDR_W(AW), .RD_LAT(RD_LAT), .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .fb_base(fb_base),
    .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .rgb(rgb), .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  // Framebuffer contents: a few fixed colour indices every 16 bytes, a hash elsewhere.
  function automatic logic [7:0] fb_mem(input logic [AW-1:0] a);
    case (a[3:0])
      4'd0:    return 8'hE0;
      4'd1:    return 8'h1C;
      4'd2:    return 8'h03;
      4'd3:    return 8'h00;
      default: return a[11:4] ^ {a[3:0], a[19:16]} ^ 8'h5A;
    endcase
  endfunction

  // RGB332 expansion by bit replication, written arithmetically.
  function automatic logic [23:0] rgb332(input logic [7:0] i);
    int r3, g3, b2;
    r3 = int'(i) / 32;
    g3 = (int'(i) / 4) % 8;
    b2 = int'(i) % 4;
    return 24'((r3 * 36 + r3 / 2) * 65536 + (g3 * 36 + g3 / 2) * 256 + b2 * 85);
  endfunction

`ifdef FB_SCANOUT_PALETTE_EN
  logic [23:0] pal_m [256];
  initial for (int i = 0; i < 256; i++) pal_m[i] = rgb332(8'(i));
`endif

  function automatic logic [23:0] colour_of(input logic [7:0] idx);
`ifdef FB_SCANOUT_PALETTE_EN
    return pal_m[idx];
`else
    return rgb332(idx);
`endif
  endfunction

  // Framebuffer responder with RD_LAT cycles of read latency.
  logic [AW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= fb_rd_addr;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign fb_rd_data = fb_mem(rd_pipe[RD_LAT-1]);

  typedef struct {
    logic          act;
    logic          hs;
    logic          vs;
    logic [AW-1:0] addr;
  } pos_t;

  typedef struct {
    logic          rd_en;
    logic [AW-1:0] addr;
    logic          fs;
    logic          de;
    logic          hs;
    logic          vs;
    logic [23:0]   rgb;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: raster position from the count of enabled edges since (re)start.
  initial begin
    pos_t          hist[$];
    pos_t          cur;
    pos_t          o;
    exp_t          e;
    int            tick;
    int            x;
    int            y;
    logic [AW-1:0] mbase;
    tick  = 0;
    mbase = '0;
    forever begin
      @(posedge clk);
      if (rst || !en) begin
        tick = 0;
        hist.delete();
        e.rd_en = 1'b0; e.addr = '0; e.fs = 1'b0; e.de = 1'b0;
        e.hs = ~HS_POL; e.vs = ~VS_POL; e.rgb = '0;
      end else begin
        x = tick % HT;
        y = tick / HT;
        if (tick == 0) mbase = fb_base;
        cur.act  = (x < HA) && (y < VA);
        cur.hs   = (x >= HA + HFP) && (x < HA + HFP + HSW);
        cur.vs   = (y >= VA + VFP) && (y < VA + VFP + VSW);
        cur.addr = AW'(int'(mbase) + y * HA + x);
        e.rd_en  = cur.act;
        e.addr   = cur.addr;
        e.fs     = (tick == 0);
        hist.push_back(cur);
        if (hist.size() > D) begin
          o     = hist.pop_front();
          e.de  = o.act;
          e.hs  = o.hs ? HS_POL : ~HS_POL;
          e.vs  = o.vs ? VS_POL : ~VS_POL;
          e.rgb = o.act ? colour_of(fb_mem(o.addr)) : 24'h0;
        end else begin
          e.de = 1'b0; e.hs = ~HS_POL; e.vs = ~VS_POL; e.rgb = '0;
        end
        tick = (tick + 1) % FRAME;
      end
`ifdef FB_SCANOUT_PALETTE_EN
      if (pal_we) pal_m[pal_idx] = pal_rgb;
`endif
      exp_q.push_back(e);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared away from the edge.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard at %0t: got no expected entry, required one per cycle", $time);
      end else begin
        e = exp_q.pop_front();
        check("fb_rd_en", 32'(fb_rd_en), 32'(e.rd_en));
        if (e.rd_en) check("fb_rd_addr", 32'(fb_rd_addr), 32'(e.addr));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("de", 32'(de), 32'(e.de));
        check("rgb", 32'(rgb), 32'(e.rgb));
        check("hsync", 32'(hsync), 32'(e.hs));
        check("vsync", 32'(vsync), 32'(e.vs));
      end
    end
  end

  function automatic logic [7:0] pick_idx();
    case ($urandom_range(5))
      0:       return 8'hE0;
      1:       return 8'h1C;
      2:       return 8'h03;
      3:       return 8'h00;
      4:       return 8'h05;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic run(input int n, input bit rnd_base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rnd_base && $urandom_range(63) == 0) fb_base = AW'($urandom);
      pal_we  = ($urandom_range(7) == 0);
      pal_idx = pick_idx();
      pal_rgb = 24'($urandom);
    end
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    fb_base = 20'h00100;
    pal_we  = 1'b0;
    pal_idx = '0;
    pal_rgb = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    run(FRAME / 2, 1'b0);
    fb_base = 20'h80000;
    run(FRAME / 2 + HT, 1'b0);
    fb_base = 20'hFFFF0;
    run(FRAME, 1'b0);
    for (int k = 0; k < 8; k++) begin
      run($urandom_range(2 * FRAME / 3, HT), 1'b1);
      if ($urandom_range(2) == 0) begin
        rst = 1'b1;
        run(2, 1'b1);
        rst = 1'b0;
      end else begin
        en = 1'b0;
        run($urandom_range(5, 1), 1'b1);
        en = 1'b1;
      end
    end
    run(FRAME + 2 * HT, 1'b1);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
